// File: rtl/asc2hex_parser_pkg.sv
// Shared constants for the ASCII-hex text parser: character codes,
// FSM state encoding and a delimiter classification helper.
package asc2hex_parser_pkg;

    // Delimiter codes
    localparam logic [7:0] ASC_SP     = 8'h20;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;

    // Hex digit range bounds
    localparam logic [7:0] ASC_0      = 8'h30;
    localparam logic [7:0] ASC_9      = 8'h39;
    localparam logic [7:0] ASC_UA     = 8'h41;
    localparam logic [7:0] ASC_UF     = 8'h46;
    localparam logic [7:0] ASC_LA     = 8'h61;
    localparam logic [7:0] ASC_LF_HEX = 8'h66;

    // IDLE is folded into ACCUM: after reset the parser simply sits in
    // ACCUM with an empty digit count.
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    // True for the characters that terminate a partial word.
    function automatic logic is_delim_code(input logic [7:0] c);
        return (c == ASC_SP) || (c == ASC_CR) || (c == ASC_LF) || (c == ASC_COMMA);
    endfunction

endpackage

// File: rtl/asc2hex_parser_asc2nib.sv
// Combinational ASCII character classifier: maps a hex digit character
// (either case) to its nibble value and flags delimiters.
module asc2nib
    import asc2hex_parser_pkg::*;
(
    input  logic [7:0] din,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic       is_delim
);

    logic [7:0] upper_off;
    logic [7:0] lower_off;

    // Offsets of the letter ranges, rebased so 'A'/'a' land on 10.
    assign upper_off = din - ASC_UA + 8'd10;
    assign lower_off = din - ASC_LA + 8'd10;

    // Classify the character and derive its nibble value.
    always_comb begin
        nib      = 4'h0;
        is_hex   = 1'b0;
        is_delim = is_delim_code(din);
        if (din >= ASC_0 && din <= ASC_9) begin
            nib    = din[3:0];
            is_hex = 1'b1;
        end else if (din >= ASC_UA && din <= ASC_UF) begin
            nib    = upper_off[3:0];
            is_hex = 1'b1;
        end else if (din >= ASC_LA && din <= ASC_LF_HEX) begin
            nib    = lower_off[3:0];
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/asc2hex_parser.sv
// Streaming ASCII-hex to binary parser. Hex digits accumulate MSB-first
// into a DIGITS-nibble word that is emitted on a valid/ready output when
// the word fills up or a delimiter ends a partial word. Invalid
// characters discard the partial word and pulse err for one cycle.
module asc2hex_parser
    import asc2hex_parser_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [4*DIGITS-1:0]   dout,
    output logic [3:0]            dout_ndig,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
    localparam logic [3:0] FULL_CNT = 4'(DIGITS);

    state_t       state_q;
    logic [W-1:0] acc_q;
    logic [3:0]   cnt_q;
    logic [W-1:0] dout_q;
    logic [3:0]   ndig_q;
    logic         dout_valid_q;
    logic         err_q;
    logic         din_ready_q;

    logic [3:0]   nib;
    logic         is_hex;
    logic         is_delim;
    logic         accept;

    // Shift-in candidates; the widened concatenation keeps DIGITS=1 legal.
    logic [W+3:0] acc_ext;
    logic [W-1:0] acc_d;
    logic [3:0]   cnt_d;

    asc2nib u_asc2nib (
        .din      (din),
        .nib      (nib),
        .is_hex   (is_hex),
        .is_delim (is_delim)
    );

    assign accept  = din_valid && din_ready_q;
    assign acc_ext = {acc_q, nib};
    assign acc_d   = acc_ext[W-1:0];
    assign cnt_d   = cnt_q + 4'd1;

    // Parser FSM with accumulator, digit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCUM;
            acc_q        <= '0;
            cnt_q        <= 4'd0;
            dout_q       <= '0;
            ndig_q       <= 4'd0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
            din_ready_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_ACCUM: begin
                    din_ready_q <= 1'b1;
                    if (accept) begin
                        if (is_hex) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            if (cnt_d == FULL_CNT) begin
                                dout_q       <= acc_d;
                                ndig_q       <= FULL_CNT;
                                dout_valid_q <= 1'b1;
                                din_ready_q  <= 1'b0;
                                state_q      <= ST_OUT;
                            end
                        end else if (is_delim) begin
                            // A delimiter with nothing collected is a no-op.
                            if (cnt_q != 4'd0) begin
                                dout_q       <= acc_q;
                                ndig_q       <= cnt_q;
                                dout_valid_q <= 1'b1;
                                din_ready_q  <= 1'b0;
                                state_q      <= ST_OUT;
                            end
                        end else begin
                            err_q <= 1'b1;
                            acc_q <= '0;
                            cnt_q <= 4'd0;
                        end
                    end
                end
                ST_OUT: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        acc_q        <= '0;
                        cnt_q        <= 4'd0;
                        din_ready_q  <= 1'b1;
                        state_q      <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_ndig  = ndig_q;
    assign dout_valid = dout_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_asc2hex_parser.sv
// Scoreboard bench for asc2hex_parser (DIGITS=2). Tests push hand-computed
// words into a queue; a negedge monitor pops and compares on each output
// handshake.
module tb_asc2hex_parser;

    localparam int DIGITS = 2;
    localparam int W = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] word;
        logic [3:0]   ndig;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   din = 8'h00;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dout;
    logic [3:0]   dout_ndig;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         err;

    int checks = 0;
    int errors = 0;
    int err_expected = 0;
    int err_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    asc2hex_parser #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_ndig  (dout_ndig),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one character and return just after the edge that accepts it.
    task automatic send(input logic [7:0] c);
        int waited;
        din = c;
        din_valid = 1'b1;
        waited = 0;
        while (!din_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: char %0h not accepted, din_ready %0b expected 1", c, din_ready);
        end
        tick();
    endtask

    task automatic idle();
        din_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [W-1:0] w, input logic [3:0] n);
        exp_t e;
        e.word = w;
        e.ndig = n;
        return e;
    endfunction

    // Monitor: scoreboard comparisons, err/valid exclusivity, hold stability.
    logic         prev_valid = 1'b0;
    logic         prev_ack = 1'b0;
    logic [W-1:0] prev_dout = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (err && dout_valid) begin
                checks++;
                errors++;
                $display("FAIL err_valid_overlap: err %0b dout_valid %0b expected not both", err, dout_valid);
            end
            if (err) err_seen++;
            if (dout_valid && prev_valid && !prev_ack && dout !== prev_dout) begin
                checks++;
                errors++;
                $display("FAIL hold_stable: dout %0h expected %0h", dout, prev_dout);
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: dout %0h ndig %0d expected none", dout, dout_ndig);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (dout !== e.word || dout_ndig !== e.ndig) begin
                        errors++;
                        $display("FAIL word: dout %0h ndig %0d expected %0h ndig %0d",
                                 dout, dout_ndig, e.word, e.ndig);
                    end else begin
                        $display("word ok: dout %0h ndig %0d", dout, dout_ndig);
                    end
                end
            end
        end
        prev_valid = dout_valid;
        prev_ack   = dout_valid && dout_ready;
        prev_dout  = dout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_ndig", 32'(dout_ndig), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", 32'(din_ready), 32'h1);

        // "3","f" back to back, dout_ready=1
        exp_q.push_back(mk(8'h3F, 4'd2));
        send("3");
        send("f");
        idle();
        chk("lat_valid", 32'(dout_valid), 32'h1);
        tick();
        chk("out_one_cycle", 32'(dout_valid), 32'h0);
        chk("ready_again", 32'(din_ready), 32'h1);

        // "A","b" auto-emits; trailing CR ignored; "a",CR partial word
        exp_q.push_back(mk(8'hAB, 4'd2));
        send("A");
        send("b");
        send(8'h0D);
        exp_q.push_back(mk(8'h0A, 4'd1));
        send("a");
        send(8'h0D);
        send(8'h0D);
        idle();
        repeat (3) tick();

        // Invalid character discards the partial word
        send("1");
        send("G");
        idle();
        err_expected++;
        chk("err_pulse", 32'(err), 32'h1);
        chk("err_no_valid", 32'(dout_valid), 32'h0);
        tick();
        chk("err_one_cycle", 32'(err), 32'h0);
        exp_q.push_back(mk(8'h25, 4'd2));
        send("2");
        send("5");
        idle();
        repeat (2) tick();

        // Backpressure: word held, input blocked, pending char waits
        dout_ready = 1'b0;
        exp_q.push_back(mk(8'h7E, 4'd2));
        send("7");
        send("E");
        din = "5";
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(dout_valid), 32'h1);
            chk("bp_dout", 32'(dout), 32'h7E);
            chk("bp_ready", 32'(din_ready), 32'h0);
            tick();
        end
        dout_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(dout_valid), 32'h0);
        chk("bp_release_ready", 32'(din_ready), 32'h1);
        exp_q.push_back(mk(8'h05, 4'd1));
        tick();
        send(8'h0A);
        idle();
        repeat (2) tick();

        // Stream "12 34,5\n" with din_valid held high
        exp_q.push_back(mk(8'h12, 4'd2));
        exp_q.push_back(mk(8'h34, 4'd2));
        exp_q.push_back(mk(8'h05, 4'd1));
        send("1");
        send("2");
        send(" ");
        send("3");
        send("4");
        send(",");
        send("5");
        send(8'h0A);
        idle();
        repeat (3) tick();

        // Reset mid-word discards the partial digit
        send("9");
        idle();
        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(dout_valid), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_ndig", 32'(dout_ndig), 32'h0);
        reset = 1'b0;
        exp_q.push_back(mk(8'h0C, 4'd1));
        send("C");
        send(8'h0D);
        idle();
        repeat (4) tick();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("err_count", 32'(err_seen), 32'(err_expected));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
